multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath (fetch, register file, sign-extend, ALU, memory).
//  Replaces the single-cycle decoder with a Moore FSM.
//  Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, driving mux selects, write enables and the 4-bit ALU operation.
//  Stalls on a memory ready handshake and counts retired instructions.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter
// PORTS
//  clk           in   1   single clock; all state updates on rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  opcode        in   6   ins[31:26] from instruction register
//  funct         in   6   ins[5:0] from instruction register
//  zero          in   1   ALU zero flag
//  mem_ready     in   1   memory has completed current read/write this cycle
//  pc_write      out  1   unconditional PC load
//  pc_write_cond out  1   PC load qualified by zero (branch)
//  i_or_d        out  1   memory address select: 0=PC, 1=ALU result
//  mem_read      out  1   memory read request
//  mem_write     out  1   memory write request
//  ir_write      out  1   load instruction register
//  reg_dst       out  1   write register select: 0=ins[20:16], 1=ins[15:11]
//  mem_to_reg    out  1   write data select: 0=ALU result, 1=memory data
//  reg_write     out  1   register file write enable
//  alu_src_a     out  1   0=PC, 1=RData1
//  alu_src_b     out  2   0=RData2, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
//  alu_op        out  4   ALU operation code
//  pc_source     out  2   0=ALU result, 1=ALU-out register, 2=jump target
//  retire        out  1   one-cycle pulse on last cycle of each legal instruction
//  illegal_op    out  1   one-cycle pulse on unsupported opcode/funct
//  instr_count   out  CNT_W  retired legal instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, instr_count=0, all outputs 0.
//  - IDLE moves unconditionally to FETCH on the first clk after rst_n deasserts.
//  - FETCH outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0.
//    ir_write and pc_write are 1 only when mem_ready=1; then go to DECODE, else hold FETCH.
//  - DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target). Next state by opcode:
//    0x23 lw / 0x2B sw -> MEM_ADDR; 0x00 R-type -> R_EXEC; 0x04 beq -> BRANCH;
//    0x08 addi -> I_EXEC; 0x02 j -> JUMP; any other -> FETCH with illegal_op=1.
//  - MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD; lw -> MEM_READ, sw -> MEM_WRITE.
//  - MEM_READ: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB.
//  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1 -> FETCH.
//  - MEM_WRITE: mem_write=1, i_or_d=1; hold until mem_ready; retire=1 on the ready cycle -> FETCH.
//  - R_EXEC: alu_src_a=1, alu_src_b=0, alu_op from funct:
//    0x20 ADD=0010, 0x22 SUB=0110, 0x24 AND=0000, 0x25 OR=0001, 0x27 NOR=1100, 0x2A SLT=0111.
//    Known funct -> R_WB; unknown funct -> FETCH with illegal_op=1, no write.
//  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1 -> FETCH.
//  - I_EXEC: alu_src_a=1, alu_src_b=2, ADD -> I_WB.
//  - I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1 -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_write_cond=1, pc_source=1, retire=1 -> FETCH.
//  - JUMP: pc_write=1, pc_source=2, retire=1 -> FETCH.
//  - Latency with mem_ready=1: lw 5, sw/R/addi 4, beq/j 3 cycles. Each mem_ready=0 cycle adds exactly one cycle.
//  - Outputs are decoded from the state register (plus funct in R_EXEC, mem_ready in FETCH/MEM_*).
//    Outputs in unlisted states are 0. mem_read and mem_write are never 1 together.
//  - instr_count increments on the same edge that ends a retire cycle.
//    It wraps from 2^CNT_W-1 to 0 and does not count illegal ops.
//  - rst_n asserted in any state, including mid-stall: immediate return to IDLE, count cleared, no partial write.
//  - Unreachable state encodings go to IDLE.
// STRUCTURE
//  - mips_ctrl_pkg: state enum (4 bits), opcode constants, funct constants, ALU op constants, alu_src_b and pc_source encodings.
//  - Sub-module alu_control: combinational funct -> {alu_op, funct_valid}.
//  - Top module holds the FSM, output decode and counter.
// TESTING
//  1. Hold rst_n=0 -> all outputs 0, instr_count=0; release -> IDLE, then FETCH next cycle with mem_read=1.
//  2. lw (opcode 0x23), mem_ready=1 -> states FETCH,DECODE,MEM_ADDR,MEM_READ,MEM_WB.
//     reg_write=1 with mem_to_reg=1 in cycle 5; instr_count 0->1.
//  3. R-type funct 0x22 -> alu_op=0110 in R_EXEC; R_WB reg_dst=1, reg_write=1.
//     funct 0x3F -> illegal_op pulse, no reg_write, count unchanged.
//  4. beq (0x04) with zero=1 -> BRANCH asserts pc_write_cond=1, pc_source=1; total 3 cycles.
//     j (0x02) -> JUMP asserts pc_write=1, pc_source=2.
//  5. sw with mem_ready=0 for 3 cycles -> MEM_WRITE held 4 cycles, mem_write stays 1, retire on the 4th; total 7 cycles.
//  6. rst_n pulsed low during MEM_READ stall -> IDLE immediately, no reg_write, instr_count=0.
//     Preload instr_count=2^CNT_W-1 via long run or force -> wraps to 0 on next retire.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes, functs, ALU ops, mux selects.
// Pure constants and one decode helper; no latency or backpressure of its own.
package mips_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_FETCH     = 4'd1;
  localparam state_t ST_DECODE    = 4'd2;
  localparam state_t ST_MEM_ADDR  = 4'd3;
  localparam state_t ST_MEM_READ  = 4'd4;
  localparam state_t ST_MEM_WB    = 4'd5;
  localparam state_t ST_MEM_WRITE = 4'd6;
  localparam state_t ST_R_EXEC    = 4'd7;
  localparam state_t ST_R_WB      = 4'd8;
  localparam state_t ST_I_EXEC    = 4'd9;
  localparam state_t ST_I_WB      = 4'd10;
  localparam state_t ST_BRANCH    = 4'd11;
  localparam state_t ST_JUMP      = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_RDATA2 = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Unsupported opcodes map to FETCH; the controller uses that to flag illegal_op.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: decode_target = ST_MEM_ADDR;
      OP_RTYPE:     decode_target = ST_R_EXEC;
      OP_BEQ:       decode_target = ST_BRANCH;
      OP_ADDI:      decode_target = ST_I_EXEC;
      OP_J:         decode_target = ST_JUMP;
      default:      decode_target = ST_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_alu_control.sv
// R-type funct to ALU operation decoder with a validity flag for unsupported functs.
// Purely combinational, zero latency; no handshake.
module alu_control
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       funct_valid
);

  always_comb begin
    alu_op      = ALU_AND;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_NOR:  alu_op = ALU_NOR;
      FN_SLT:  alu_op = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style multi-cycle MIPS sequencer with retired-instruction counter.
// lw 5, sw/R/addi 4, beq/j 3 cycles; each mem_ready=0 cycle in FETCH/MEM_READ/MEM_WRITE adds one.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             retire,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic [3:0]       funct_alu_op;
  logic             funct_valid;

  // zero gates pc_write_cond inside the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  alu_control u_alu_control (
    .funct       (funct),
    .alu_op      (funct_alu_op),
    .funct_valid (funct_valid)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = ST_FETCH;
      ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
      ST_DECODE:    state_d = decode_target(opcode);
      ST_MEM_ADDR:  state_d = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
      ST_R_EXEC:    state_d = funct_valid ? ST_R_WB : ST_FETCH;
      ST_R_WB:      state_d = ST_FETCH;
      ST_I_EXEC:    state_d = ST_I_WB;
      ST_I_WB:      state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RDATA2;
    alu_op        = ALU_AND;
    pc_source     = PCSRC_ALU;
    retire        = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b  = SRCB_IMM_SL;
        alu_op     = ALU_ADD;
        illegal_op = (decode_target(opcode) == ST_FETCH);
      end
      ST_MEM_ADDR, ST_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
      end
      ST_R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = funct_alu_op;
        illegal_op = ~funct_valid;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      ST_I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        retire        = 1'b1;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        retire    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    instr_count_d = instr_count_q;
    if (retire) instr_count_d = instr_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: per-cycle expected control vectors queued per instruction, popped and checked each cycle.
module tb_multicycle_control;

  localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110, A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001, A_NOR = 4'b1100, A_SLT = 4'b0111;
  localparam logic [19:0] FULL = 20'hFFFFF;
  localparam logic [19:0] NO_ALUOP = 20'hFFF0F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, retire, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_op;
  logic [3:0] instr_count;
  logic [19:0] obs;

  typedef struct {
    string       tag;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [19:0] exp;
    logic [19:0] mask;
  } step_t;

  step_t      sbq[$];
  logic [5:0] cur_op, cur_fn;
  logic       cur_z;
  logic [3:0] cnt_model;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .retire(retire), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, retire, illegal_op};

  function automatic logic [19:0] cv(input logic pcw, pcwc, iod, mr, mw, irw, rd, m2r, rw, asa,
                                     input logic [1:0] asb, input logic [3:0] aop,
                                     input logic [1:0] pcs, input logic ret, ill);
    cv = {pcw, pcwc, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, ret, ill};
  endfunction

  task automatic chk_vec(input string tag, input logic [19:0] e, input logic [19:0] m);
    n_cmp++;
    assert ((obs & m) === (e & m)) else begin
      n_bad++;
      $error("FAIL %s: ctrl=%05h expected %05h (mask %05h)", tag, obs, e, m);
    end
    n_cmp++;
    assert (!(mem_read && mem_write)) else begin
      n_bad++;
      $error("FAIL %s_rw_excl: mem_read=%b mem_write=%b expected not both", tag, mem_read, mem_write);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] e);
    n_cmp++;
    assert (instr_count === e) else begin
      n_bad++;
      $error("FAIL %s_count: instr_count=%0d expected %0d", tag, instr_count, e);
    end
  endtask

  task automatic push(input string tag, input logic rdy, input logic [19:0] e, input logic [19:0] m);
    step_t s;
    s.tag = tag; s.op = cur_op; s.fn = cur_fn; s.z = cur_z;
    s.rdy = rdy; s.exp = e; s.mask = m;
    sbq.push_back(s);
  endtask

  task automatic p_fetch(input logic rdy);
    push("fetch", rdy, cv(rdy,0,0,1,0,rdy,0,0,0,0, 2'd1, A_ADD, 2'd0, 0,0), FULL);
  endtask
  task automatic p_decode(input logic ill);
    push("decode", 1'b1, cv(0,0,0,0,0,0,0,0,0,0, 2'd3, A_ADD, 2'd0, 0,ill), FULL);
  endtask

  // Pops one expected vector per clock, drives that cycle's inputs, then checks outputs and count.
  task automatic drain();
    step_t s;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      @(negedge clk);
      opcode = s.op; funct = s.fn; zero = s.z; mem_ready = s.rdy;
      #1;
      chk_vec(s.tag, s.exp, s.mask);
      chk_cnt(s.tag, cnt_model);
      if (s.exp[1]) cnt_model = cnt_model + 4'd1;
    end
  endtask

  task automatic run_lw();
    cur_op = 6'h23; cur_fn = 6'h00; cur_z = 1'b0;
    p_fetch(1); p_decode(0);
    push("lw_addr", 1, cv(0,0,0,0,0,0,0,0,0,1, 2'd2, A_ADD, 2'd0, 0,0), FULL);
    push("lw_read", 1, cv(0,0,1,1,0,0,0,0,0,0, 2'd0, A_AND, 2'd0, 0,0), FULL);
    push("lw_wb",   1, cv(0,0,0,0,0,0,0,1,1,0, 2'd0, A_AND, 2'd0, 1,0), FULL);
    drain();
  endtask

  task automatic run_r(input logic [5:0] fn, input logic [3:0] aop);
    cur_op = 6'h00; cur_fn = fn; cur_z = 1'b0;
    p_fetch(1); p_decode(0);
    push("r_exec", 1, cv(0,0,0,0,0,0,0,0,0,1, 2'd0, aop, 2'd0, 0,0), FULL);
    push("r_wb",   1, cv(0,0,0,0,0,0,1,0,1,0, 2'd0, A_AND, 2'd0, 1,0), FULL);
    drain();
  endtask

  task automatic run_j(input logic stall);
    cur_op = 6'h02; cur_fn = 6'h00; cur_z = 1'b0;
    if (stall) p_fetch(0);
    p_fetch(1); p_decode(0);
    push("jump", 1, cv(1,0,0,0,0,0,0,0,0,0, 2'd0, A_AND, 2'd2, 1,0), FULL);
    drain();
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    cnt_model = 4'd0;

    // Reset: outputs zero before any clock edge and while held.
    #3;
    chk_vec("reset_async", 20'h0, FULL);
    chk_cnt("reset_async", 4'd0);
    @(negedge clk); #1;
    chk_vec("reset_held", 20'h0, FULL);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_vec("idle", 20'h0, FULL);
    chk_cnt("idle", 4'd0);

    run_lw();
    run_r(6'h22, A_SUB);

    // Unknown funct: illegal pulse in R_EXEC, straight back to FETCH without write or retire.
    cur_op = 6'h00; cur_fn = 6'h3F; cur_z = 1'b0;
    p_fetch(1); p_decode(0);
    push("r_illegal", 1, cv(0,0,0,0,0,0,0,0,0,1, 2'd0, A_AND, 2'd0, 0,1), NO_ALUOP);
    drain();

    cur_op = 6'h04; cur_fn = 6'h00; cur_z = 1'b1;
    p_fetch(1); p_decode(0);
    push("beq", 1, cv(0,1,0,0,0,0,0,0,0,1, 2'd0, A_SUB, 2'd1, 1,0), FULL);
    drain();

    run_j(1'b1);

    // sw with three not-ready cycles in MEM_WRITE: seven cycles total.
    cur_op = 6'h2B; cur_fn = 6'h00; cur_z = 1'b0;
    p_fetch(1); p_decode(0);
    push("sw_addr", 1, cv(0,0,0,0,0,0,0,0,0,1, 2'd2, A_ADD, 2'd0, 0,0), FULL);
    for (int i = 0; i < 3; i++)
      push("sw_stall", 0, cv(0,0,1,0,1,0,0,0,0,0, 2'd0, A_AND, 2'd0, 0,0), FULL);
    push("sw_done", 1, cv(0,0,1,0,1,0,0,0,0,0, 2'd0, A_AND, 2'd0, 1,0), FULL);
    drain();

    cur_op = 6'h08; cur_fn = 6'h00; cur_z = 1'b0;
    p_fetch(1); p_decode(0);
    push("addi_exec", 1, cv(0,0,0,0,0,0,0,0,0,1, 2'd2, A_ADD, 2'd0, 0,0), FULL);
    push("addi_wb",   1, cv(0,0,0,0,0,0,0,0,1,0, 2'd0, A_AND, 2'd0, 1,0), FULL);
    drain();

    run_r(6'h20, A_ADD);
    run_r(6'h24, A_AND);
    run_r(6'h25, A_OR);
    run_r(6'h27, A_NOR);
    run_r(6'h2A, A_SLT);

    // Unsupported opcode: illegal pulse in DECODE, back to FETCH.
    cur_op = 6'h3F; cur_fn = 6'h00; cur_z = 1'b0;
    p_fetch(1); p_decode(1);
    drain();

    // Reset mid MEM_READ stall: immediate IDLE, no write-back, count cleared.
    cur_op = 6'h23; cur_fn = 6'h00; cur_z = 1'b0;
    p_fetch(1); p_decode(0);
    push("lw_addr2", 1, cv(0,0,0,0,0,0,0,0,0,1, 2'd2, A_ADD, 2'd0, 0,0), FULL);
    push("lw_stall", 0, cv(0,0,1,1,0,0,0,0,0,0, 2'd0, A_AND, 2'd0, 0,0), FULL);
    push("lw_stall", 0, cv(0,0,1,1,0,0,0,0,0,0, 2'd0, A_AND, 2'd0, 0,0), FULL);
    drain();
    #2;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk_vec("rst_midstall", 20'h0, FULL);
    chk_cnt("rst_midstall", 4'd0);
    cnt_model = 4'd0;
    @(negedge clk); #1;
    chk_vec("rst_midstall_held", 20'h0, FULL);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_vec("idle2", 20'h0, FULL);

    // Sixteen jumps wrap the 4-bit counter from 15 back to 0.
    for (int i = 0; i < 16; i++) run_j(1'b0);
    cur_op = 6'h02;
    p_fetch(0);
    drain();
    chk_cnt("wrap", 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
